// File: rtl/modinv_fermat_2423.sv
// rtl/modinv_fermat_2423.sv - modular inverse over GF(2423) via Fermat exponentiation a^(Q-2)
// One Barrett-reduced 12x12 modmul per cycle; fixed 17-cycle square-and-multiply schedule.
module modinv_fermat_2423 (
  input  logic        clk,
  input  logic        rst,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic [11:0] din_a,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic [11:0] dout_r,
  output logic        dout_err
);

  localparam int unsigned   K   = 12;
  localparam int unsigned   W   = 12;
  localparam logic [W-1:0]  Q   = 12'd2423;
  localparam logic [12:0]   MU  = 13'd6924;
  localparam logic [W-1:0]  EXP = 12'b1001_0111_0101;

  typedef enum logic [1:0] {IDLE, SQR, MUL, DONE} state_t;

  state_t       state;
  logic [W-1:0] base;
  logic [W-1:0] acc;
  logic [3:0]   idx;
  logic         zero_flag;

  logic [W-1:0] a_red;
  logic [W-1:0] mul_y;
  logic [W-1:0] mm_out;
  logic [22:0]  p;
  logic [23:0]  q_est;
  logic [W-1:0] t;
  logic [22:0]  tq;
  logic [22:0]  r0;
  logic [22:0]  r1;
  logic [22:0]  r2;
  logic         last_step;

  // 4095 < 2Q, so one conditional subtract brings any operand into range.
  assign a_red = (din_a >= Q) ? din_a - Q : din_a;

  assign mul_y = (state == MUL) ? base : acc;

  always_comb begin
    p     = 23'(acc) * 23'(mul_y);
    q_est = 24'(p >> K) * 24'(MU);
    t     = W'(q_est >> K);
    tq    = 23'(t) * 23'(Q);
    r0    = p - tq;
    // Second correction absorbs the worst-case Barrett underestimate of the quotient.
    r1    = (r0 >= 23'(Q)) ? r0 - 23'(Q) : r0;
    r2    = (r1 >= 23'(Q)) ? r1 - 23'(Q) : r1;
    mm_out = W'(r2);
  end

  assign last_step = ((state == SQR) && !EXP[idx] && (idx == 4'd0)) ||
                     ((state == MUL) && (idx == 4'd0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      din_ready  <= 1'b1;
      dout_valid <= 1'b0;
      dout_r     <= '0;
      dout_err   <= 1'b0;
      base       <= '0;
      acc        <= '0;
      idx        <= '0;
      zero_flag  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (din_valid && din_ready) begin
            // Exponent MSB is 1, so the accumulator starts at the base itself.
            base      <= a_red;
            acc       <= a_red;
            idx       <= 4'd10;
            zero_flag <= (a_red == '0);
            din_ready <= 1'b0;
            state     <= SQR;
          end
        end
        SQR: begin
          acc <= mm_out;
          if (EXP[idx]) begin
            state <= MUL;
          end else if (!last_step) begin
            idx <= idx - 4'd1;
          end
        end
        MUL: begin
          acc <= mm_out;
          if (!last_step) begin
            idx   <= idx - 4'd1;
            state <= SQR;
          end
        end
        DONE: begin
          if (dout_ready) begin
            dout_valid <= 1'b0;
            din_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (last_step) begin
        state      <= DONE;
        dout_valid <= 1'b1;
        dout_r     <= mm_out;
        dout_err   <= zero_flag;
      end
    end
  end

endmodule

// File: tb/tb_modinv_fermat_2423.sv
// tb/tb_modinv_fermat_2423.sv - scoreboard bench for modinv_fermat_2423
// Expected inverses come from an extended-Euclid model; a negedge monitor pops and compares.
module tb_modinv_fermat_2423;

  localparam int Q = 2423;

  logic        clk = 1'b0;
  logic        rst;
  logic        din_valid;
  logic        din_ready;
  logic [11:0] din_a;
  logic        dout_valid;
  logic        dout_ready;
  logic [11:0] dout_r;
  logic        dout_err;

  always #5 clk = ~clk;

  modinv_fermat_2423 dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .din_a      (din_a),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_r     (dout_r),
    .dout_err   (dout_err)
  );

  typedef struct {
    int r;
    int err;
    int acc_cyc;
    int a;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_acc = -1;
  bit   chk_interval = 1'b0;
  bit   rand_ready = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int ref_inv(input int a);
    int am, t, nt, r, nr, qq, tmp;
    am = a % Q;
    if (am == 0) return 0;
    t = 0; nt = 1; r = Q; nr = am;
    while (nr != 0) begin
      qq = r / nr;
      tmp = t - qq * nt; t = nt; nt = tmp;
      tmp = r - qq * nr; r = nr; nr = tmp;
    end
    if (t < 0) t += Q;
    return t;
  endfunction

  task automatic issue(input int a);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!din_ready) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        check("din_ready_timeout", 0, 1);
        return;
      end
    end
    din_valid = 1'b1;
    din_a     = 12'(a);
    e.r       = ref_inv(a);
    e.err     = ((a % Q) == 0) ? 1 : 0;
    e.acc_cyc = cyc + 1;
    e.a       = a;
    sb.push_back(e);
    if (chk_interval && last_acc >= 0) check("issue_interval", cyc + 1 - last_acc, 19);
    last_acc = cyc + 1;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (sb.size() != 0 || dout_valid) begin
      @(negedge clk);
      n++;
      if (n > 400) begin
        check("drain_timeout", 0, 1);
        return;
      end
    end
  endtask

  // Monitor: compare on each rising dout_valid; while held, the result must not move.
  always @(negedge clk) begin : monitor
    bit   prev_valid;
    exp_t e;
    int   held_r;
    int   held_err;
    if (dout_valid && !prev_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_output", 1, 0);
        held_r = dout_r; held_err = dout_err;
      end else begin
        e = sb.pop_front();
        check("dout_r", dout_r, e.r);
        check("dout_err", dout_err, e.err);
        check("latency", cyc - e.acc_cyc, 17);
        if (e.err == 0) check("inverse_product", ((e.a % Q) * int'(dout_r)) % Q, 1);
        held_r = e.r; held_err = e.err;
      end
    end else if (dout_valid && prev_valid) begin
      check("hold_dout_r", dout_r, held_r);
      check("hold_dout_err", dout_err, held_err);
      check("din_ready_while_done", din_ready, 0);
    end
    prev_valid = dout_valid;
  end

  always @(negedge clk) if (rand_ready) dout_ready = 1'($urandom_range(0, 1));

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete, got %0d checks, expected completion", checks);
    $fatal(1);
  end

  initial begin
    int dir_ops[7];
    int cnt;
    int n;
    dir_ops = '{2, 3, 1, 2422, 2425, 0, 2423};
    rst = 1'b1; din_valid = 1'b0; din_a = '0; dout_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_din_ready", din_ready, 1);
    check("reset_dout_valid", dout_valid, 0);
    check("reset_dout_r", dout_r, 0);
    check("reset_dout_err", dout_err, 0);
    rst = 1'b0;

    foreach (dir_ops[i]) issue(dir_ops[i]);
    wait_idle();

    // Reset mid-computation drops the pending result.
    issue(7);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_dout_valid", dout_valid, 0);
    check("rst_din_ready", din_ready, 1);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_din_ready", din_ready, 1);
    cnt = 0;
    repeat (25) @(negedge clk) if (dout_valid) cnt++;
    check("post_rst_no_output", cnt, 0);
    issue(3);
    wait_idle();

    // Backpressure with an ignored din_valid pulse.
    dout_ready = 1'b0;
    issue(5);
    n = 0;
    while (!dout_valid && n < 40) begin @(negedge clk); n++; end
    check("bp_result_seen", dout_valid, 1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) begin din_valid = 1'b1; din_a = 12'd9; end
      if (i == 4) din_valid = 1'b0;
      check("bp_dout_valid_held", dout_valid, 1);
      check("bp_din_ready_low", din_ready, 0);
    end
    dout_ready = 1'b1;
    wait_idle();
    @(negedge clk);
    check("bp_din_ready_after", din_ready, 1);
    repeat (25) @(negedge clk);

    // Random operands with random consumer stalls.
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) issue(int'($urandom_range(0, 4095)));
    wait_idle();
    rand_ready = 1'b0;
    dout_ready = 1'b1;

    // Exhaustive back-to-back sweep.
    last_acc = -1;
    chk_interval = 1'b1;
    for (int a = 1; a < Q; a++) issue(a);
    chk_interval = 1'b0;
    wait_idle();

    check("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
